// File: rtl/pim_scheduler_if.sv
// Job/issue/result handshake bundle between the scheduler and its neighbours.
// master = partitioner/units/aggregator side, slave = scheduler side.
interface pim_scheduler_if #(
    parameter int NUM_PIM   = 4,
    parameter int TAG_WIDTH = 8
);
    localparam int UW = $clog2(NUM_PIM);

    logic                 job_valid;
    logic                 job_ready;
    logic [TAG_WIDTH-1:0] job_tag;
    logic [NUM_PIM-1:0]   pim_valid;
    logic [NUM_PIM-1:0]   pim_result_valid;
    logic                 out_valid;
    logic                 out_ready;
    logic [UW-1:0]        out_unit;
    logic [TAG_WIDTH-1:0] out_tag;
    logic                 out_timeout;
    logic [UW:0]          busy_count;
    logic                 err;

    modport master (
        output job_valid, job_tag, pim_result_valid, out_ready,
        input  job_ready, pim_valid, out_valid, out_unit, out_tag,
               out_timeout, busy_count, err
    );

    modport slave (
        input  job_valid, job_tag, pim_result_valid, out_ready,
        output job_ready, pim_valid, out_valid, out_unit, out_tag,
               out_timeout, busy_count, err
    );
endinterface

// File: rtl/pim_scheduler.sv
// Round-robin job scheduler for NUM_PIM multiply units with a registered result stage.
// Optional per-unit watchdog enabled by defining PIM_SCHED_TIMEOUT_EN.
module pim_sched_slot #(
    parameter int TAG_WIDTH = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dispatch,
    input  logic                 result,
    input  logic                 rel,
    input  logic [TAG_WIDTH-1:0] tag_in,
    output logic                 idle,
    output logic                 done,
    output logic                 active_next,
    output logic [TAG_WIDTH-1:0] tag,
    output logic                 timed_out,
    output logic                 err_pulse
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} slot_state_e;

    slot_state_e          state_q, state_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic                 to_q, to_d;
    logic                 wd_expire;

`ifdef PIM_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d     = cnt_q;
        wd_expire = 1'b0;
        if (dispatch) begin
            cnt_d = '0;
        end else if (state_q == S_BUSY) begin
            cnt_d     = cnt_q + 1'b1;
            wd_expire = (cnt_d == CW'(TIMEOUT));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
`else
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        tag_d     = tag_q;
        to_d      = to_q;
        err_pulse = 1'b0;
        case (state_q)
            S_IDLE: begin
                err_pulse = result;
                if (dispatch) begin
                    state_d = S_BUSY;
                    tag_d   = tag_in;
                    to_d    = 1'b0;
                end
            end
            S_BUSY: begin
                // A real result arriving on the expiry cycle wins over the watchdog.
                if (result) begin
                    state_d = S_DONE;
                end else if (wd_expire) begin
                    state_d   = S_DONE;
                    to_d      = 1'b1;
                    err_pulse = 1'b1;
                end
            end
            S_DONE: begin
                err_pulse = result;
                if (rel) begin
                    state_d = S_IDLE;
                    to_d    = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            tag_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            to_q    <= to_d;
        end
    end

    assign idle        = (state_q == S_IDLE);
    assign done        = (state_q == S_DONE);
    assign active_next = (state_d != S_IDLE);
    assign tag         = tag_q;
    assign timed_out   = to_q;
endmodule

module pim_scheduler #(
    parameter int NUM_PIM   = 4,
    parameter int TAG_WIDTH = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic               clk,
    input  logic               rst,
    pim_scheduler_if.slave     bus
);
    localparam int UW = $clog2(NUM_PIM);
    localparam int CW = UW + 1;

    logic [NUM_PIM-1:0]                idle, done, active_nx, err_pulse, to_flag;
    logic [NUM_PIM-1:0]                disp_oh, rel_oh, cand;
    logic [NUM_PIM-1:0][TAG_WIDTH-1:0] tags;

    logic [UW-1:0]        disp_ptr_q, disp_ptr_d, ret_ptr_q, ret_ptr_d;
    logic [UW-1:0]        disp_sel, ret_sel;
    logic                 disp_hit, ret_hit, dispatch, rel, load;
    logic                 out_valid_q, out_valid_d, out_to_q, out_to_d, err_q, err_d;
    logic [UW-1:0]        out_unit_q, out_unit_d;
    logic [TAG_WIDTH-1:0] out_tag_q, out_tag_d;
    logic [CW-1:0]        busy_count_q, busy_count_d;

    function automatic logic [UW-1:0] wrap_add(logic [UW-1:0] p, int i);
        return UW'((int'(p) + i) % NUM_PIM);
    endfunction

    for (genvar g = 0; g < NUM_PIM; g++) begin : g_slot
        pim_sched_slot #(.TAG_WIDTH(TAG_WIDTH), .TIMEOUT(TIMEOUT)) u_slot (
            .clk         (clk),
            .rst         (rst),
            .dispatch    (disp_oh[g]),
            .result      (bus.pim_result_valid[g]),
            .rel         (rel_oh[g]),
            .tag_in      (bus.job_tag),
            .idle        (idle[g]),
            .done        (done[g]),
            .active_next (active_nx[g]),
            .tag         (tags[g]),
            .timed_out   (to_flag[g]),
            .err_pulse   (err_pulse[g])
        );
    end

    // Both scans walk downward so the nearest hit past the pointer wins.
    always_comb begin
        disp_hit = 1'b0;
        disp_sel = '0;
        ret_hit  = 1'b0;
        ret_sel  = '0;
        for (int i = NUM_PIM - 1; i >= 0; i--) begin
            if (idle[wrap_add(disp_ptr_q, i)]) begin
                disp_hit = 1'b1;
                disp_sel = wrap_add(disp_ptr_q, i);
            end
            if (cand[wrap_add(ret_ptr_q, i)]) begin
                ret_hit = 1'b1;
                ret_sel = wrap_add(ret_ptr_q, i);
            end
        end
    end

    assign bus.job_ready = |idle;
    assign dispatch      = rst && bus.job_valid && disp_hit;
    assign rel           = out_valid_q && bus.out_ready;
    assign load          = !out_valid_q || rel;
    assign cand          = done & ~rel_oh;

    always_comb begin
        disp_oh = '0;
        rel_oh  = '0;
        if (dispatch) disp_oh[disp_sel] = 1'b1;
        if (rel)      rel_oh[out_unit_q] = 1'b1;
    end

    always_comb begin
        disp_ptr_d   = dispatch ? wrap_add(disp_sel, 1) : disp_ptr_q;
        ret_ptr_d    = ret_ptr_q;
        out_valid_d  = out_valid_q;
        out_unit_d   = out_unit_q;
        out_tag_d    = out_tag_q;
        out_to_d     = out_to_q;
        err_d        = err_q | (|err_pulse);
        busy_count_d = '0;
        for (int i = 0; i < NUM_PIM; i++) busy_count_d = busy_count_d + CW'(active_nx[i]);
        if (load) begin
            out_valid_d = ret_hit;
            if (ret_hit) begin
                out_unit_d = ret_sel;
                out_tag_d  = tags[ret_sel];
                out_to_d   = to_flag[ret_sel];
                ret_ptr_d  = wrap_add(ret_sel, 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            disp_ptr_q   <= '0;
            ret_ptr_q    <= '0;
            out_valid_q  <= 1'b0;
            out_unit_q   <= '0;
            out_tag_q    <= '0;
            out_to_q     <= 1'b0;
            busy_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            disp_ptr_q   <= disp_ptr_d;
            ret_ptr_q    <= ret_ptr_d;
            out_valid_q  <= out_valid_d;
            out_unit_q   <= out_unit_d;
            out_tag_q    <= out_tag_d;
            out_to_q     <= out_to_d;
            busy_count_q <= busy_count_d;
            err_q        <= err_d;
        end
    end

    assign bus.pim_valid   = disp_oh;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_unit    = out_unit_q;
    assign bus.out_tag     = out_tag_q;
    assign bus.out_timeout = out_to_q;
    assign bus.busy_count  = busy_count_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_pim_scheduler.sv
// Directed vector bench for pim_scheduler (NUM_PIM=4): one table row per clock cycle
// plus a hand-written watchdog/no-watchdog sequence.
module tb_pim_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pim_scheduler_if #(.NUM_PIM(4), .TAG_WIDTH(8)) bus ();

  pim_scheduler #(.NUM_PIM(4), .TAG_WIDTH(8), .TIMEOUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       rst, jv;
    logic [7:0] tag;
    logic [3:0] prv;
    logic       ordy;
    logic       jr;
    logic [3:0] pv;
    logic       ov;
    logic [1:0] ou;
    logic [7:0] ot;
    logic [2:0] bc;
    logic       err;
    logic       full;   // also check unit/tag when out_valid is expected low
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic r, logic jv, logic [7:0] tag, logic [3:0] prv, logic ordy,
                              logic jr, logic [3:0] pv, logic ov, logic [1:0] ou, logic [7:0] ot,
                              logic [2:0] bc, logic err, logic full);
    vec_t v;
    v.rst = r; v.jv = jv; v.tag = tag; v.prv = prv; v.ordy = ordy;
    v.jr = jr; v.pv = pv; v.ov = ov; v.ou = ou; v.ot = ot; v.bc = bc; v.err = err; v.full = full;
    return v;
  endfunction

  initial begin
    bit got;
    int n;

    //             rst jv tag    prv     ordy | jr  pv      ov ou  ot     bc err full
    vecs.push_back(mk(0, 1, 8'h55, 4'h0, 1,    1, 4'h0,   0, 0, 8'h00, 0, 0, 1)); // 0 pim_valid gated in reset
    vecs.push_back(mk(1, 1, 8'h11, 4'h0, 1,    1, 4'h1,   0, 0, 8'h00, 0, 0, 0)); // 1 single job T
    vecs.push_back(mk(1, 0, 8'h00, 4'h1, 1,    1, 4'h0,   0, 0, 8'h00, 1, 0, 0)); // 2 T+1 pulse
    vecs.push_back(mk(1, 0, 8'h00, 4'h0, 1,    1, 4'h0,   0, 0, 8'h00, 1, 0, 0)); // 3 T+2 done
    vecs.push_back(mk(1, 0, 8'h00, 4'h0, 1,    1, 4'h0,   1, 0, 8'h11, 1, 0, 0)); // 4 T+3 out
    vecs.push_back(mk(1, 0, 8'h00, 4'h0, 1,    1, 4'h0,   0, 0, 8'h00, 0, 0, 0)); // 5 released
    vecs.push_back(mk(0, 0, 8'h00, 4'h0, 1,    1, 4'h0,   0, 0, 8'h00, 0, 0, 0)); // 6 reset
    vecs.push_back(mk(1, 1, 8'h01, 4'h0, 1,    1, 4'h1,   0, 0, 8'h00, 0, 0, 0)); // 7 fill
    vecs.push_back(mk(1, 1, 8'h02, 4'h0, 1,    1, 4'h2,   0, 0, 8'h00, 1, 0, 0)); // 8
    vecs.push_back(mk(1, 1, 8'h03, 4'h0, 1,    1, 4'h4,   0, 0, 8'h00, 2, 0, 0)); // 9
    vecs.push_back(mk(1, 1, 8'h04, 4'h0, 1,    1, 4'h8,   0, 0, 8'h00, 3, 0, 0)); // 10
    vecs.push_back(mk(1, 1, 8'h05, 4'h0, 1,    0, 4'h0,   0, 0, 8'h00, 4, 0, 0)); // 11 bank full
    vecs.push_back(mk(1, 0, 8'h00, 4'h1, 1,    0, 4'h0,   0, 0, 8'h00, 4, 0, 0)); // 12 unit0 done
    vecs.push_back(mk(1, 0, 8'h00, 4'h0, 1,    0, 4'h0,   0, 0, 8'h00, 4, 0, 0)); // 13
    vecs.push_back(mk(1, 0, 8'h00, 4'h0, 1,    0, 4'h0,   1, 0, 8'h01, 4, 0, 0)); // 14 -> ret_ptr=1
    vecs.push_back(mk(1, 1, 8'h21, 4'h0, 1,    1, 4'h1,   0, 0, 8'h00, 3, 0, 0)); // 15 disp_ptr wrapped
    vecs.push_back(mk(1, 0, 8'h00, 4'h5, 1,    0, 4'h0,   0, 0, 8'h00, 4, 0, 0)); // 16 units 2,0 pulse
    vecs.push_back(mk(1, 0, 8'h00, 4'h0, 1,    0, 4'h0,   0, 0, 8'h00, 4, 0, 0)); // 17
    vecs.push_back(mk(1, 0, 8'h00, 4'h0, 1,    0, 4'h0,   1, 2, 8'h03, 4, 0, 0)); // 18 unit2 first
    vecs.push_back(mk(1, 1, 8'h33, 4'h0, 0,    1, 4'h4,   1, 0, 8'h21, 3, 0, 0)); // 19 then unit0, stall
    for (int i = 0; i < 9; i++)
      vecs.push_back(mk(1, 0, 8'h00, 4'h0, 0,  0, 4'h0,   1, 0, 8'h21, 4, 0, 0)); // 20..28 held
    vecs.push_back(mk(1, 0, 8'h00, 4'h0, 1,    0, 4'h0,   1, 0, 8'h21, 4, 0, 0)); // 29 accept
    vecs.push_back(mk(1, 0, 8'h00, 4'h0, 1,    1, 4'h0,   0, 0, 8'h00, 3, 0, 0)); // 30 job_ready rises
    vecs.push_back(mk(1, 0, 8'h00, 4'h1, 1,    1, 4'h0,   0, 0, 8'h00, 3, 0, 0)); // 31 pulse on idle unit
    vecs.push_back(mk(1, 0, 8'h00, 4'h0, 1,    1, 4'h0,   0, 0, 8'h00, 3, 1, 0)); // 32 err set
    vecs.push_back(mk(0, 1, 8'h44, 4'h0, 1,    1, 4'h0,   0, 0, 8'h00, 3, 1, 0)); // 33 reset mid-job
    vecs.push_back(mk(1, 0, 8'h00, 4'h0, 1,    1, 4'h0,   0, 0, 8'h00, 0, 0, 1)); // 34 reset values
    vecs.push_back(mk(1, 0, 8'h00, 4'h8, 1,    1, 4'h0,   0, 0, 8'h00, 0, 0, 1)); // 35 late pulse unit3
    vecs.push_back(mk(1, 0, 8'h00, 4'h0, 1,    1, 4'h0,   0, 0, 8'h00, 0, 1, 1)); // 36 err again

    bus.job_valid = 1'b0; bus.job_tag = '0; bus.pim_result_valid = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      vec_t e;
      bit bad;
      e = vecs[i];
      @(negedge clk);
      rst = e.rst; bus.job_valid = e.jv; bus.job_tag = e.tag;
      bus.pim_result_valid = e.prv; bus.out_ready = e.ordy;
      #4;
      n_vec++;
      bad = (bus.job_ready !== e.jr) || (bus.pim_valid !== e.pv) || (bus.out_valid !== e.ov) ||
            (bus.busy_count !== e.bc) || (bus.err !== e.err) || (bus.out_timeout !== 1'b0);
      if ((e.ov || e.full) && ((bus.out_unit !== e.ou) || (bus.out_tag !== e.ot))) bad = 1'b1;
      if (bad) begin
        n_bad++;
        $display("FAIL vec%0d: got jr=%b pv=%b ov=%b unit=%0d tag=%h to=%b bc=%0d err=%b; want jr=%b pv=%b ov=%b unit=%0d tag=%h to=0 bc=%0d err=%b",
                 i, bus.job_ready, bus.pim_valid, bus.out_valid, bus.out_unit, bus.out_tag,
                 bus.out_timeout, bus.busy_count, bus.err, e.jr, e.pv, e.ov, e.ou, e.ot, e.bc, e.err);
      end
    end

    // Silent unit: watchdog forces a result after 64 BUSY cycles, otherwise it waits forever.
    @(negedge clk);
    rst = 1'b0; bus.job_valid = 1'b0; bus.pim_result_valid = '0; bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1; bus.job_valid = 1'b1; bus.job_tag = 8'h77;
    #4;
    n_vec++;
    if (bus.pim_valid !== 4'b0001) begin
      n_bad++;
      $display("FAIL wd_dispatch: got pv=%b want 0001", bus.pim_valid);
    end
    @(negedge clk);
    bus.job_valid = 1'b0;
    got = 1'b0;
    n = 1;
    #4;
    while (n < 100 && !got) begin
      if (bus.out_valid === 1'b1) got = 1'b1;
      else begin
        @(negedge clk);
        #4;
        n++;
      end
    end
    n_vec++;
`ifdef PIM_SCHED_TIMEOUT_EN
    if (!got || n != 66 || bus.out_timeout !== 1'b1 || bus.err !== 1'b1 || bus.out_tag !== 8'h77) begin
      n_bad++;
      $display("FAIL watchdog: got seen=%0d cycle=%0d to=%b err=%b tag=%h; want seen=1 cycle=66 to=1 err=1 tag=77",
               got, n, bus.out_timeout, bus.err, bus.out_tag);
    end
`else
    if (got || bus.busy_count !== 3'd1 || bus.out_timeout !== 1'b0 || bus.err !== 1'b0) begin
      n_bad++;
      $display("FAIL no_watchdog: got seen=%0d bc=%0d to=%b err=%b; want seen=0 bc=1 to=0 err=0",
               got, bus.busy_count, bus.out_timeout, bus.err);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
